piano_key_render: RTL and testbench



---
 rtl/piano_key_render_if.sv | 19 +
 rtl/piano_key_render.sv | 115 +++++++++++
 tb/tb_piano_key_render.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/piano_key_render_if.sv
// Pixel request/response bundle between the VGA timing controller (master)
// and the piano keyboard pixel source (slave).
interface piano_key_render_if;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [12:0] key_state;
  logic [23:0] pix_data;
  logic        frame_tick;

  modport master (
    output pos_x, pos_y, key_state,
    input  pix_data, frame_tick
  );

  modport slave (
    input  pos_x, pos_y, key_state,
    output pix_data, frame_tick
  );
endinterface

// File: rtl/piano_key_render.sv
// One-octave piano keyboard pixel source: one-cycle registered RGB888 per
// requested pixel, key state latched once per frame with per-key flash ageing.
module piano_key_render #(
  parameter int          KEY_TOP      = 320,
  parameter int          BLACK_BOTTOM = 420,
  parameter int          WHITE_W      = 80,
  parameter int          BLACK_HALF   = 20,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [23:0] BG_COLOR     = 24'h202040,
  parameter logic [23:0] WHITE_COLOR  = 24'hFFFFFF,
  parameter logic [23:0] BLACK_COLOR  = 24'h101010,
  parameter logic [23:0] BORDER_COLOR = 24'h000000,
  parameter logic [23:0] PRESS_COLOR  = 24'h3080FF,
  parameter logic [23:0] FLASH_COLOR  = 24'hFFD000
) (
  input  logic                vga_clk,
  input  logic                sys_rst,
  piano_key_render_if.slave   bus
);

  localparam int N_KEYS = 13;
  // Black keys sit on white boundaries 1,2,4,5,6 (x = 80..480); chromatic maps.
  localparam int BLK_POS [5] = '{1, 2, 4, 5, 6};
  localparam int BLK_IDX [5] = '{1, 3, 6, 8, 10};
  localparam int WHT_IDX [8] = '{0, 2, 4, 5, 7, 9, 11, 12};

  logic [12:0] r_latched;
  logic [3:0]  r_age [N_KEYS];
  logic [23:0] r_pix;
  logic        r_frame_tick;

  logic        w_valid;
  logic        w_frame_end;
  logic [2:0]  w_white;
  logic [9:0]  w_offset;
  logic        w_black_hit;
  logic [23:0] w_black_color;
  logic [23:0] w_white_color;
  logic [23:0] w_pix_next;

  function automatic logic [23:0] key_color(input logic       latched,
                                            input logic [3:0] age,
                                            input logic [23:0] base);
    if (!latched)                     return base;
    else if (age < 4'(FLASH_FRAMES))  return FLASH_COLOR;
    else                              return PRESS_COLOR;
  endfunction

  assign w_valid     = (bus.pos_x != 10'h3ff) && (bus.pos_y != 10'h3ff);
  assign w_frame_end = (bus.pos_x == 10'd639) && (bus.pos_y == 10'd479);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_white       = '0;
    w_black_hit   = 1'b0;
    w_black_color = BLACK_COLOR;
    w_white_color = WHITE_COLOR;
    w_pix_next    = '0;

    for (int i = 1; i < 8; i++)
      if (bus.pos_x >= 10'(WHITE_W * i)) w_white = 3'(i);
    w_offset = bus.pos_x - 10'(WHITE_W * int'(w_white));

    for (int j = 0; j < 5; j++) begin
      if (bus.pos_x >= 10'(WHITE_W * BLK_POS[j] - BLACK_HALF) &&
          bus.pos_x <  10'(WHITE_W * BLK_POS[j] + BLACK_HALF)) begin
        w_black_hit   = 1'b1;
        w_black_color = key_color(r_latched[BLK_IDX[j]], r_age[BLK_IDX[j]], BLACK_COLOR);
      end
    end

    for (int i = 0; i < 8; i++)
      if (w_white == 3'(i))
        w_white_color = key_color(r_latched[WHT_IDX[i]], r_age[WHT_IDX[i]], WHITE_COLOR);

    if (!w_valid)
      w_pix_next = '0;
    else if (bus.pos_y < 10'(KEY_TOP))
      w_pix_next = BG_COLOR;
    else if (bus.pos_y < 10'(BLACK_BOTTOM) && w_black_hit)
      w_pix_next = w_black_color;
    else if (bus.pos_y == 10'(KEY_TOP) || w_offset == 10'd0 ||
             w_offset == 10'(WHITE_W - 1))
      w_pix_next = BORDER_COLOR;
    else
      w_pix_next = w_white_color;
  end

  // NOTE: the age array is small and its reset value is observable, so it is
  // reset explicitly like ordinary registers; sequential state uses <= only.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_pix        <= '0;
      r_frame_tick <= 1'b0;
      r_latched    <= '0;
      for (int k = 0; k < N_KEYS; k++) r_age[k] <= '0;
    end else begin
      r_pix        <= w_pix_next;
      r_frame_tick <= w_frame_end;
      if (w_frame_end) begin
        r_latched <= bus.key_state;
        for (int k = 0; k < N_KEYS; k++) begin
          if (bus.key_state[k] && r_latched[k])
            r_age[k] <= (r_age[k] == 4'd15) ? 4'd15 : r_age[k] + 4'd1;
          else
            r_age[k] <= 4'd0;
        end
      end
    end
  end

  assign bus.pix_data   = r_pix;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_piano_key_render.sv
// Self-checking bench for piano_key_render: directed steps plus randomized
// frames compared against a geometric reference model of the keyboard.
module tb_piano_key_render;

  localparam logic [23:0] BG     = 24'h202040;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;
  localparam logic [23:0] BLACK  = 24'h101010;
  localparam logic [23:0] BORDER = 24'h000000;
  localparam logic [23:0] PRESS  = 24'h3080FF;
  localparam logic [23:0] FLASH  = 24'hFFD000;

  logic vga_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #20 vga_clk = ~vga_clk;

  piano_key_render_if bus ();
  piano_key_render dut (.vga_clk(vga_clk), .sys_rst(sys_rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the keyboard shows during the current frame.
  logic [12:0] m_latched;
  int          m_age [13];
  int          blk_center [5] = '{80, 160, 320, 400, 480};
  int          blk_key    [5] = '{1, 3, 6, 8, 10};
  int          wht_key    [8] = '{0, 2, 4, 5, 7, 9, 11, 12};

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] m_key(input int k, input logic [23:0] base);
    if (!m_latched[k]) return base;
    return (m_age[k] < 8) ? FLASH : PRESS;
  endfunction

  function automatic logic [23:0] m_pix(input int x, input int y);
    if (x == 1023 || y == 1023) return 24'h0;
    if (y < 320) return BG;
    if (y < 420)
      for (int j = 0; j < 5; j++)
        if (x >= blk_center[j] - 20 && x < blk_center[j] + 20)
          return m_key(blk_key[j], BLACK);
    if (y == 320 || x % 80 == 0 || x % 80 == 79) return BORDER;
    return m_key(wht_key[x / 80], WHITE);
  endfunction

  task automatic m_reset();
    m_latched = '0;
    for (int k = 0; k < 13; k++) m_age[k] = 0;
  endtask

  task automatic m_latch(input logic [12:0] ks);
    for (int k = 0; k < 13; k++)
      if (ks[k] && m_latched[k]) m_age[k] = (m_age[k] >= 15) ? 15 : m_age[k] + 1;
      else                       m_age[k] = 0;
    m_latched = ks;
  endtask

  // Present one request, then check the pixel and tick one edge later.
  task automatic req(input int x, input int y, input string tag);
    logic [23:0] exp_pix;
    logic        exp_tick;
    @(negedge vga_clk);
    bus.pos_x = 10'(x);
    bus.pos_y = 10'(y);
    exp_pix  = sys_rst ? 24'h0 : m_pix(x, y);
    exp_tick = !sys_rst && x == 639 && y == 479;
    @(posedge vga_clk);
    #1;
    check({tag, "_pix"}, bus.pix_data, exp_pix);
    check({tag, "_tick"}, {23'h0, bus.frame_tick}, {23'h0, exp_tick});
    if (sys_rst)       m_reset();
    else if (exp_tick) m_latch(bus.key_state);
  endtask

  task automatic latch(input logic [12:0] ks);
    @(negedge vga_clk);
    bus.key_state = ks;
    req(639, 479, "latch");
  endtask

  int bx [10] = '{59, 60, 99, 100, 140, 179, 300, 339, 500, 639};
  int by [4]  = '{319, 320, 419, 420};

  initial begin
    m_reset();
    bus.pos_x = 10'd100;
    bus.pos_y = 10'd100;
    bus.key_state = '0;

    // Reset held three cycles with a live request.
    sys_rst = 1'b1;
    for (int i = 0; i < 3; i++) req(100, 100, "reset");
    @(negedge vga_clk);
    sys_rst = 1'b0;
    req(100, 100, "post_reset");
    check("post_reset_lit", bus.pix_data, BG);

    // Latency and basic regions.
    req(10, 50, "bg");
    req(1023, 1023, "blank");
    check("blank_lit", bus.pix_data, 24'h0);
    req(40, 450, "white");
    check("white_lit", bus.pix_data, WHITE);
    req(80, 450, "border");
    check("border_lit", bus.pix_data, BORDER);
    req(80, 350, "black1");
    check("black1_lit", bus.pix_data, BLACK);

    // Boundary sweep around black spans, KEY_TOP and BLACK_BOTTOM.
    foreach (by[j]) foreach (bx[i]) req(bx[i], by[j], "edge");

    // Frame latch with key 0: last pixel of this frame still old colour.
    @(negedge vga_clk);
    bus.key_state = 13'h001;
    req(40, 450, "prelatch");
    check("prelatch_lit", bus.pix_data, WHITE);
    latch(13'h001);
    check("tick_lit", {23'h0, bus.frame_tick}, 24'h1);
    req(40, 450, "flash0");
    check("flash0_lit", bus.pix_data, FLASH);

    // Hold key 0 for 20 latches total: flash frames 0..7, then press, saturating.
    for (int f = 1; f < 20; f++) begin
      latch(13'h001);
      req(40, 450, "age");
      req(639, 478, "noframe");
    end
    check("age_sat_lit", bus.pix_data, 24'h0 | m_pix(639, 478));
    req(40, 450, "sat");
    check("sat_lit", bus.pix_data, PRESS);

    // Black key F# pressed alongside key 0.
    latch(13'h041);
    req(320, 400, "fsharp");
    check("fsharp_lit", bus.pix_data, FLASH);
    req(320, 430, "fs_border");
    check("fs_border_lit", bus.pix_data, BORDER);
    req(300, 430, "fs_white");
    check("fs_white_lit", bus.pix_data, WHITE);

    // Release key 0, then repress: age must restart at 0.
    latch(13'h040);
    req(40, 450, "release");
    check("release_lit", bus.pix_data, WHITE);
    latch(13'h041);
    req(40, 450, "repress");
    check("repress_lit", bus.pix_data, FLASH);

    // Randomized frames with occasional key changes and blank requests.
    for (int f = 0; f < 40; f++) begin
      logic [12:0] ks;
      ks = bus.key_state;
      if ($urandom_range(3) == 0) ks = 13'($urandom);
      for (int p = 0; p < 24; p++) begin
        if ($urandom_range(15) == 0) req(1023, $urandom_range(479), "rnd_blank");
        else req($urandom_range(639), $urandom_range(479), "rnd");
      end
      latch(ks);
    end

    // Reset mid-line clears output and latched keys.
    latch(13'h001);
    req(40, 450, "pre_rst");
    @(negedge vga_clk);
    sys_rst = 1'b1;
    req(40, 450, "mid_rst");
    check("mid_rst_lit", bus.pix_data, 24'h0);
    @(negedge vga_clk);
    sys_rst = 1'b0;
    req(40, 450, "after_rst");
    check("after_rst_lit", bus.pix_data, WHITE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
